// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA gradient stage: window geometry,
// sequencer state encoding and a window element index helper.
package cfa_pkg;

  localparam int unsigned PIX_W     = 12;
  localparam int unsigned WIN_SIZE  = 5;
  localparam int unsigned WIN_HALF  = 2;
  localparam int unsigned NUM_LINES = WIN_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } grad_ctrl_state_t;

  // Flat element index of window position (r,c); multiply by PIX_W for the bit offset.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return r * WIN_SIZE + c;
  endfunction

endpackage

// File: rtl/line_buf.sv
// Four parallel line buffers sharing one column address. Reads return the
// contents before the current write, so each line ages into the next-older
// one and the incoming pixel enters the newest line.
module line_buf #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PIX_W     = 12,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                en_i,
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [PIX_W-1:0]                    din_i,
  output logic [NUM_LINES-1:0][PIX_W-1:0]     rd_o
);

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PIX_W-1:0] wr_data;

    if (l == NUM_LINES - 1) begin : g_newest
      assign wr_data = din_i;
    end else begin : g_older
      assign wr_data = rd_o[l+1];
    end

    assign rd_o[l] = mem_q[addr_i];

    // Column write; storage is not reset, windows never see stale lines.
    always_ff @(posedge clk) begin
      if (en_i) begin
        mem_q[addr_i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/grad_window_ctrl.sv
// Frame-level sequencer for the CFA gradient stage: buffers four lines,
// builds a 5x5 window per interior pixel, pulses grad_start and tags the
// delayed gradient results with their center coordinate.
// Optional macro GRAD_CTRL_WIN_CNT_EN adds a 16-bit per-frame window counter.
module grad_window_ctrl #(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned PIX_W    = cfa_pkg::PIX_W,
  parameter int unsigned GRAD_LAT = 2
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     frame_start,
  input  logic [PIX_W-1:0]                                         pix_in,
  input  logic                                                     pix_valid,
  output logic                                                     pix_ready,
  output logic [cfa_pkg::WIN_SIZE*cfa_pkg::WIN_SIZE*PIX_W-1:0]     win,
  output logic                                                     grad_start,
  output logic                                                     out_valid,
  output logic [$clog2(IMG_H)-1:0]                                 out_row,
  output logic [$clog2(IMG_W)-1:0]                                 out_col,
  output logic                                                     busy,
  output logic                                                     frame_done
`ifdef GRAD_CTRL_WIN_CNT_EN
  ,
  output logic [15:0]                                              win_count
`endif
);

  import cfa_pkg::*;

  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned WIN_W = WIN_SIZE * WIN_SIZE * PIX_W;
  localparam int unsigned CNT_W = $clog2(GRAD_LAT + 1);

  grad_ctrl_state_t state_q, state_d;

  logic [ROW_W-1:0] in_row_q, in_row_d;
  logic [COL_W-1:0] in_col_q, in_col_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             grad_start_q, grad_start_d;
  logic [ROW_W-1:0] ctr_row_q, ctr_row_d;
  logic [COL_W-1:0] ctr_col_q, ctr_col_d;
  logic             pix_ready_q, pix_ready_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic [GRAD_LAT-1:0]            vld_pipe_q, vld_pipe_d;
  logic [GRAD_LAT-1:0][ROW_W-1:0] row_pipe_q, row_pipe_d;
  logic [GRAD_LAT-1:0][COL_W-1:0] col_pipe_q, col_pipe_d;

  logic                               accept_c;
  logic                               win_done_c;
  logic                               last_pix_c;
  logic [NUM_LINES-1:0][PIX_W-1:0]    lb_rd_c;
  logic [WIN_SIZE-1:0][PIX_W-1:0]     new_col_c;

  assign accept_c   = pix_valid && pix_ready_q;
  assign win_done_c = accept_c
                      && (in_row_q >= ROW_W'(WIN_SIZE - 1))
                      && (in_col_q >= COL_W'(WIN_SIZE - 1));
  assign last_pix_c = accept_c
                      && (in_row_q == ROW_W'(IMG_H - 1))
                      && (in_col_q == COL_W'(IMG_W - 1));

  // Row 4 of the new column is the live pixel, rows 0..3 come from the buffers.
  assign new_col_c = {pix_in, lb_rd_c};

  line_buf #(
    .DEPTH     (IMG_W),
    .PIX_W     (PIX_W),
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (COL_W)
  ) u_line_buf (
    .clk    (clk),
    .en_i   (accept_c),
    .addr_i (in_col_q),
    .din_i  (pix_in),
    .rd_o   (lb_rd_c)
  );

  // Next-state, counters, window shift and registered-output next values.
  always_comb begin
    state_d      = state_q;
    in_row_d     = in_row_q;
    in_col_d     = in_col_q;
    drain_cnt_d  = drain_cnt_q;
    win_d        = win_q;
    grad_start_d = 1'b0;
    ctr_row_d    = ctr_row_q;
    ctr_col_d    = ctr_col_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d  = FILL;
          in_row_d = '0;
          in_col_d = '0;
        end
      end
      FILL: begin
        if (last_pix_c) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (win_done_c) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_pix_c) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == CNT_W'(GRAD_LAT)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end else begin
          drain_cnt_d = CNT_W'(drain_cnt_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) begin
      if (in_col_q == COL_W'(IMG_W - 1)) begin
        in_col_d = '0;
        in_row_d = (in_row_q == ROW_W'(IMG_H - 1)) ? '0 : ROW_W'(in_row_q + 1'b1);
      end else begin
        in_col_d = COL_W'(in_col_q + 1'b1);
      end

      for (int unsigned r = 0; r < WIN_SIZE; r++) begin
        for (int unsigned c = 0; c < WIN_SIZE - 1; c++) begin
          win_d[win_idx(r, c)*PIX_W +: PIX_W] = win_q[win_idx(r, c + 1)*PIX_W +: PIX_W];
        end
        win_d[win_idx(r, WIN_SIZE - 1)*PIX_W +: PIX_W] = new_col_c[r];
      end
    end

    if (win_done_c) begin
      grad_start_d = 1'b1;
      ctr_row_d    = ROW_W'(in_row_q - ROW_W'(WIN_HALF));
      ctr_col_d    = COL_W'(in_col_q - COL_W'(WIN_HALF));
    end

    pix_ready_d = (state_d == FILL) || (state_d == RUN);
    busy_d      = (state_d != IDLE);
  end

  // Delay line aligning start/center with the gradient result latency.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    row_pipe_d    = row_pipe_q;
    col_pipe_d    = col_pipe_q;
    vld_pipe_d[0] = grad_start_q;
    row_pipe_d[0] = ctr_row_q;
    col_pipe_d[0] = ctr_col_q;
    for (int unsigned i = 1; i < GRAD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      row_pipe_d[i] = row_pipe_q[i-1];
      col_pipe_d[i] = col_pipe_q[i-1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_row_q     <= '0;
      in_col_q     <= '0;
      drain_cnt_q  <= '0;
      win_q        <= '0;
      grad_start_q <= 1'b0;
      ctr_row_q    <= '0;
      ctr_col_q    <= '0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      vld_pipe_q   <= '0;
      row_pipe_q   <= '0;
      col_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_row_q     <= in_row_d;
      in_col_q     <= in_col_d;
      drain_cnt_q  <= drain_cnt_d;
      win_q        <= win_d;
      grad_start_q <= grad_start_d;
      ctr_row_q    <= ctr_row_d;
      ctr_col_q    <= ctr_col_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      vld_pipe_q   <= vld_pipe_d;
      row_pipe_q   <= row_pipe_d;
      col_pipe_q   <= col_pipe_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign win        = win_q;
  assign grad_start = grad_start_q;
  assign out_valid  = vld_pipe_q[GRAD_LAT-1];
  assign out_row    = row_pipe_q[GRAD_LAT-1];
  assign out_col    = col_pipe_q[GRAD_LAT-1];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

`ifdef GRAD_CTRL_WIN_CNT_EN
  logic [15:0] win_count_q, win_count_d;

  // Per-frame result counter, held after the frame ends.
  always_comb begin
    win_count_d = win_count_q;
    if ((state_q == IDLE) && frame_start) begin
      win_count_d = '0;
    end else if (vld_pipe_q[GRAD_LAT-1]) begin
      win_count_d = 16'(win_count_q + 16'd1);
    end
  end

  // Window counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_count_q <= '0;
    end else begin
      win_count_q <= win_count_d;
    end
  end

  assign win_count = win_count_q;
`endif

endmodule
